conv_sched: RTL and testbench
=============================

# conv_sched

Address-generation and sequencing controller for the convolution datapath. On `start` it walks every output pixel of an M-channel output feature map and issues bias, input and weight read addresses in a fixed order to the synchronous input, weight and bias memories. Those memories return data one cycle after the address. The block emits valid, first and last strobes aligned to that returned data, so the MAC/accumulator datapath needs no counters of its own. It replaces hard-coded loop logic inside the CNN top and drives its `I_addr`/`W_addr`/`B_addr` ports directly.

## Interface
Parameters:
- `N`, 3: input channels
- `M`, 3: output channels (filters)
- `R`, 28: input rows
- `C`, 28: input columns
- `K`, 4: square kernel size
- `S`, 1: stride
- Derived: `RP = (R-K)/S+1`, `CP = (C-K)/S+1`, `T = M*RP*CP*(K*K*N+1)` issue cycles per run

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; synchronous and active-high, so it is sampled only on a `clk` edge
- `start`  in  1  run request, sampled each edge
- `busy`  out  1  high from the edge that accepts `start` until `complete` rises
- `complete`  out  1  level; high after the run ends, cleared by the next accepted `start` or by `rst`
- `B_addr`  out  32  bias address = m
- `I_addr`  out  32  input address = n*R*C + (r*S+i)*C + (c*S+j)
- `W_addr`  out  32  weight address = ((m*N+n)*K+i)*K+j
- `bias_vld`  out  1  `B_dout` is valid this cycle (the bias for the current pixel)
- `mac_vld`  out  1  `I_dout`/`W_dout` form a valid product term this cycle
- `mac_first`  out  1  with `mac_vld`: first term of a pixel
- `mac_last`  out  1  with `mac_vld`: last term of a pixel; the datapath writes its result on this cycle
- `out_idx`  out  32  output address m*RP*CP + r*CP + c; valid while `mac_last`

## Operation
- States: IDLE, BIAS, MAC, DRAIN, DONE.
- IDLE/DONE + `start` high → BIAS at that edge; `busy` rises and `complete` falls at the same edge.
- `start` is ignored while `busy`.
- BIAS (1 cycle):
  - drive `B_addr` = m
  - → MAC
- MAC (K*K*N cycles):
  - drive `I_addr`/`W_addr` for the current (n,i,j)
  - loop order: n outermost, then i, then j (j fastest)
  - after the last term: if pixels remain, → BIAS of the next pixel
  - otherwise → DRAIN
- Pixel order: m outermost, then r, then c (c fastest); pixels issue back-to-back with no gaps.
- DRAIN (1 cycle):
  - no new address
  - final `mac_vld`/`mac_last` emitted
  - → DONE
- DONE:
  - `complete`=1, `busy`=0
  - hold until `start` or `rst`
- Strobe alignment: `bias_vld`, `mac_vld`, `mac_first`, `mac_last`, `out_idx` are registered copies of the issue-cycle flags, delayed exactly 1 cycle.
  - `mac_first`: term (n,i,j)=(0,0,0)
  - `mac_last`: term (N-1,K-1,K-1)
- Address arithmetic:
  - Generated with incremental adders and counters; no multipliers in the per-cycle path.
  - Values must equal the formulas above, unsigned 32-bit, with no wrap for legal parameters.
- Outside issue cycles, address outputs hold their last issued value.
- Reset: every output = 0, state IDLE. A mid-run `rst` aborts at that edge, with no valid strobe on any later cycle. This includes the delayed strobe of the cycle before reset.

## Timing
- E0 = edge that samples `start`=1 in IDLE/DONE.
- Cycle k = the period following edge E0+k-1, so cycle 1 = first BIAS issue.
- Issue cycles: 1..T.
- `bias_vld` of pixel p: cycle p*(K*K*N+1)+2.
- `mac_vld`: the K*K*N cycles immediately after each `bias_vld`.
- Final `mac_last`: cycle T+1, the DRAIN cycle.
- `complete` rises and `busy` falls at cycle T+2.
- Throughput: one memory issue per cycle, 100% utilisation while `busy`.
- Simultaneous `rst` and `start`: `rst` wins.
- `start` held high continuously: a new run is accepted at the first edge in DONE.

## Test plan
- N=1,M=1,R=C=4,K=3,S=1 (RP=CP=2, T=40):
  - `start` pulse → `B_addr`=0 in cycle 1
  - `I_addr` 0,1,2,4,5,6,8,9,10 in cycles 2-10
  - `mac_last` with `out_idx`=0 in cycle 11
  - `complete` in cycle 42
- Same config, pixel (r,c)=(0,1) first `I_addr`=1 and pixel (1,0) first `I_addr`=4 → four `mac_last` pulses with `out_idx` 0,1,2,3.
- N=1,M=1,R=C=5,K=3,S=2: pixel (1,1) issues first `I_addr`=12 and last `I_addr`=24; `out_idx`=3.
- Defaults (N=M=3,R=C=28,K=4): `T`=91875; exactly 1875 `mac_last` pulses; `W_addr` for m=2 first term = 96; `complete` at cycle 91877. Compare against the golden output file via `out_idx`.
- `rst` asserted at cycle 500 of a default run → all strobes 0 from the next cycle, `busy`=0, `complete`=0; a later `start` restarts from `B_addr`=0.
- `start` re-pulsed while `busy` → ignored, with identical pulse count and timing. `start` in DONE → `complete` drops at E0 and a full second run follows.

Source files
------------

// File: rtl/conv_sched.sv
// conv_sched: address generator and sequencer for the convolution datapath.
// For every output pixel (m outer, r, c inner) it issues one bias read followed
// by K*K*N input/weight reads (n outer, i, j inner), back to back. The strobes
// are delayed by one cycle so they line up with the synchronous memory data.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      run request (ignored while busy)
//   busy       run in progress
//   complete   run finished; held until next accepted start or rst
//   B_addr     bias address (m)
//   I_addr     input feature map address
//   W_addr     weight address
//   bias_vld   bias data valid this cycle
//   mac_vld    input/weight data form a product term this cycle
//   mac_first  first term of a pixel
//   mac_last   last term of a pixel
//   out_idx    output address of the pixel finishing on mac_last
module conv_sched #(
    parameter int unsigned N = 3,
    parameter int unsigned M = 3,
    parameter int unsigned R = 28,
    parameter int unsigned C = 28,
    parameter int unsigned K = 4,
    parameter int unsigned S = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        complete,
    output logic [31:0] B_addr,
    output logic [31:0] I_addr,
    output logic [31:0] W_addr,
    output logic        bias_vld,
    output logic        mac_vld,
    output logic        mac_first,
    output logic        mac_last,
    output logic [31:0] out_idx
);

    localparam int unsigned RP    = (R - K) / S + 1;
    localparam int unsigned CP    = (C - K) / S + 1;
    localparam int unsigned TERMS = K * K * N;

    localparam int unsigned NW  = (N  > 1) ? $clog2(N)  : 1;
    localparam int unsigned MW  = (M  > 1) ? $clog2(M)  : 1;
    localparam int unsigned KW  = (K  > 1) ? $clog2(K)  : 1;
    localparam int unsigned RPW = (RP > 1) ? $clog2(RP) : 1;
    localparam int unsigned CPW = (CP > 1) ? $clog2(CP) : 1;

    localparam logic [31:0] PLANE_STEP = 32'(R * C);
    localparam logic [31:0] ROW_STEP   = 32'(C);
    localparam logic [31:0] PIX_COL    = 32'(S);
    localparam logic [31:0] PIX_ROW    = 32'(S * C);
    localparam logic [31:0] FILT_STEP  = 32'(TERMS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_accept;
    logic w_iss_bias;
    logic w_iss_mac;

    // Loop counters for the term/pixel currently being issued.
    logic [NW-1:0]  r_n;
    logic [KW-1:0]  r_i;
    logic [KW-1:0]  r_j;
    logic [CPW-1:0] r_c;
    logic [RPW-1:0] r_r;
    logic [MW-1:0]  r_m;

    // Running address bases, updated with adders only.
    logic [31:0] r_pix_base;   // r*S*C + c*S
    logic [31:0] r_row_base;   // r*S*C
    logic [31:0] r_chan_ptr;   // pix_base + n*R*C
    logic [31:0] r_row_ptr;    // chan_ptr + i*C
    logic [31:0] r_w_base;     // m*K*K*N
    logic [31:0] r_pix_idx;    // sequential pixel number == output address

    logic w_j_last;
    logic w_i_last;
    logic w_n_last;
    logic w_term_last;
    logic w_term_first;
    logic w_c_last;
    logic w_r_last;
    logic w_m_last;
    logic w_pix_last;

    assign w_j_last     = (r_j == KW'(K - 1));
    assign w_i_last     = (r_i == KW'(K - 1));
    assign w_n_last     = (r_n == NW'(N - 1));
    assign w_term_last  = w_j_last && w_i_last && w_n_last;
    assign w_term_first = (r_n == '0) && (r_i == '0) && (r_j == '0);
    assign w_c_last     = (r_c == CPW'(CP - 1));
    assign w_r_last     = (r_r == RPW'(RP - 1));
    assign w_m_last     = (r_m == MW'(M - 1));
    assign w_pix_last   = w_c_last && w_r_last && w_m_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and issue-cycle flags.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_iss_bias  = 1'b0;
        w_iss_mac   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_BIAS;
                    w_accept    = 1'b1;
                end
            end
            ST_BIAS: begin
                w_iss_bias  = 1'b1;
                w_state_nxt = ST_MAC;
            end
            ST_MAC: begin
                w_iss_mac = 1'b1;
                if (w_term_last) begin
                    w_state_nxt = w_pix_last ? ST_DRAIN : ST_BIAS;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status, delayed strobes, counters and address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            complete   <= 1'b0;
            bias_vld   <= 1'b0;
            mac_vld    <= 1'b0;
            mac_first  <= 1'b0;
            mac_last   <= 1'b0;
            out_idx    <= '0;
            B_addr     <= '0;
            I_addr     <= '0;
            W_addr     <= '0;
            r_n        <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_c        <= '0;
            r_r        <= '0;
            r_m        <= '0;
            r_pix_base <= '0;
            r_row_base <= '0;
            r_chan_ptr <= '0;
            r_row_ptr  <= '0;
            r_w_base   <= '0;
            r_pix_idx  <= '0;
        end else begin
            busy      <= (w_state_nxt == ST_BIAS) || (w_state_nxt == ST_MAC) ||
                         (w_state_nxt == ST_DRAIN);
            complete  <= (w_state_nxt == ST_DONE);

            // Strobes are the issue flags one cycle late, matching memory latency.
            bias_vld  <= w_iss_bias;
            mac_vld   <= w_iss_mac;
            mac_first <= w_iss_mac && w_term_first;
            mac_last  <= w_iss_mac && w_term_last;
            if (w_iss_mac && w_term_last) begin
                out_idx <= r_pix_idx;
            end

            if (w_accept) begin
                r_m        <= '0;
                r_r        <= '0;
                r_c        <= '0;
                r_pix_base <= '0;
                r_row_base <= '0;
                r_w_base   <= '0;
                r_pix_idx  <= '0;
                B_addr     <= '0;
            end

            // Leaving BIAS: first term of the pixel.
            if (w_iss_bias) begin
                r_n        <= '0;
                r_i        <= '0;
                r_j        <= '0;
                r_chan_ptr <= r_pix_base;
                r_row_ptr  <= r_pix_base;
                I_addr     <= r_pix_base;
                W_addr     <= r_w_base;
            end

            if (w_iss_mac) begin
                if (!w_term_last) begin
                    // Weights for one filter are contiguous in (n,i,j) order.
                    W_addr <= W_addr + 32'd1;
                    if (!w_j_last) begin
                        r_j    <= r_j + KW'(1);
                        I_addr <= I_addr + 32'd1;
                    end else if (!w_i_last) begin
                        r_j       <= '0;
                        r_i       <= r_i + KW'(1);
                        r_row_ptr <= r_row_ptr + ROW_STEP;
                        I_addr    <= r_row_ptr + ROW_STEP;
                    end else begin
                        r_j        <= '0;
                        r_i        <= '0;
                        r_n        <= r_n + NW'(1);
                        r_chan_ptr <= r_chan_ptr + PLANE_STEP;
                        r_row_ptr  <= r_chan_ptr + PLANE_STEP;
                        I_addr     <= r_chan_ptr + PLANE_STEP;
                    end
                end else if (!w_pix_last) begin
                    // Advance to the next pixel; its BIAS issues next cycle.
                    r_pix_idx <= r_pix_idx + 32'd1;
                    if (!w_c_last) begin
                        r_c        <= r_c + CPW'(1);
                        r_pix_base <= r_pix_base + PIX_COL;
                    end else if (!w_r_last) begin
                        r_c        <= '0;
                        r_r        <= r_r + RPW'(1);
                        r_row_base <= r_row_base + PIX_ROW;
                        r_pix_base <= r_row_base + PIX_ROW;
                    end else begin
                        r_c        <= '0;
                        r_r        <= '0;
                        r_m        <= r_m + MW'(1);
                        r_row_base <= '0;
                        r_pix_base <= '0;
                        r_w_base   <= r_w_base + FILT_STEP;
                        B_addr     <= 32'(r_m) + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed checks of conv_sched in three configurations
// (small stride-1, small stride-2, default) using a cycle-vector table
// plus timing-model driven run watchers.
module tb_conv_sched;

    logic       clk;
    logic [2:0] st;
    logic [2:0] rs;

    typedef struct packed {
        logic        busy;
        logic        complete;
        logic        bv;
        logic        mv;
        logic        mf;
        logic        ml;
        logic [31:0] b;
        logic [31:0] i;
        logic [31:0] w;
        logic [31:0] out;
    } obs_t;

    typedef struct packed {
        logic rst;
        logic start;
        obs_t exp;
    } vec_t;

    logic        busy_a, comp_a, bv_a, mv_a, mf_a, ml_a;
    logic [31:0] b_a, i_a, w_a, out_a;
    logic        busy_b, comp_b, bv_b, mv_b, mf_b, ml_b;
    logic [31:0] b_b, i_b, w_b, out_b;
    logic        busy_d, comp_d, bv_d, mv_d, mf_d, ml_d;
    logic [31:0] b_d, i_d, w_d, out_d;

    obs_t o_a, o_b, o_d, o;

    int n_cmp;
    int n_fail;

    conv_sched #(.N(1), .M(1), .R(4), .C(4), .K(3), .S(1)) u_a (
        .clk(clk), .rst(rs[0]), .start(st[0]), .busy(busy_a), .complete(comp_a),
        .B_addr(b_a), .I_addr(i_a), .W_addr(w_a), .bias_vld(bv_a), .mac_vld(mv_a),
        .mac_first(mf_a), .mac_last(ml_a), .out_idx(out_a)
    );

    conv_sched #(.N(1), .M(1), .R(5), .C(5), .K(3), .S(2)) u_b (
        .clk(clk), .rst(rs[1]), .start(st[1]), .busy(busy_b), .complete(comp_b),
        .B_addr(b_b), .I_addr(i_b), .W_addr(w_b), .bias_vld(bv_b), .mac_vld(mv_b),
        .mac_first(mf_b), .mac_last(ml_b), .out_idx(out_b)
    );

    conv_sched u_d (
        .clk(clk), .rst(rs[2]), .start(st[2]), .busy(busy_d), .complete(comp_d),
        .B_addr(b_d), .I_addr(i_d), .W_addr(w_d), .bias_vld(bv_d), .mac_vld(mv_d),
        .mac_first(mf_d), .mac_last(ml_d), .out_idx(out_d)
    );

    assign o_a = {busy_a, comp_a, bv_a, mv_a, mf_a, ml_a, b_a, i_a, w_a, out_a};
    assign o_b = {busy_b, comp_b, bv_b, mv_b, mf_b, ml_b, b_b, i_b, w_b, out_b};
    assign o_d = {busy_d, comp_d, bv_d, mv_d, mf_d, ml_d, b_d, i_d, w_d, out_d};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int sel);
        @(posedge clk);
        #1;
        case (sel)
            0:       o = o_a;
            1:       o = o_b;
            default: o = o_d;
        endcase
    endtask

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, k, act, exp);
        end
    endtask

    task automatic check_obs(input string name, input int k, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h want %h", name, k, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic bz, input logic cp,
                                input logic bv, input logic mv, input logic mf, input logic ml,
                                input int b, input int i, input int w, input int out);
        vec_t v;
        v.rst   = r;
        v.start = s;
        v.exp   = {bz, cp, bv, mv, mf, ml, 32'(b), 32'(i), 32'(w), 32'(out)};
        return v;
    endfunction

    // Follows one run from cycle 1 (caller has start=1 before the accepting edge),
    // checking every cycle against the timing model and the address formulas.
    task automatic watch(input int sel, input int cn, input int cm, input int cr, input int cc,
                         input int ck, input int cs, input int lim, input int repulse,
                         output int n_last, output int t_done);
        int rp, cp, terms, npix, t, ph, p, m, r, c;
        logic in_run;
        logic [5:0] es, as_;
        rp     = (cr - ck) / cs + 1;
        cp     = (cc - ck) / cs + 1;
        terms  = ck * ck * cn;
        npix   = cm * rp * cp;
        t      = npix * (terms + 1);
        n_last = 0;
        t_done = 0;
        for (int k = 1; k <= lim; k++) begin
            step(sel);
            st[sel] = (k == repulse);
            ph     = (k >= 2) ? (k - 2) % (terms + 1) : 0;
            p      = (k >= 2) ? (k - 2) / (terms + 1) : 0;
            in_run = (k >= 2) && (p < npix);
            m      = p / (rp * cp);
            r      = (p % (rp * cp)) / cp;
            c      = p % cp;
            es  = {k <= t + 1, k >= t + 2, in_run && ph == 0, in_run && ph != 0,
                   in_run && ph == 1, in_run && ph == terms};
            as_ = {o.busy, o.complete, o.bv, o.mv, o.mf, o.ml};
            check("strobes", k, 32'(as_), 32'(es));
            if (in_run && ph == 0) begin
                check("bias B_addr", k, o.b, 32'(m));
                check("first I_addr", k, o.i, 32'(r * cs * cc + c * cs));
                check("first W_addr", k, o.w, 32'(m * terms));
            end
            if (in_run && ph == terms) begin
                check("out_idx", k, o.out, 32'(p));
                check("last I_addr", k, o.i,
                      32'((cn - 1) * cr * cc + (r * cs + ck - 1) * cc + c * cs + ck - 1));
                check("last W_addr", k, o.w, 32'(m * terms + terms - 1));
            end
            if (o.ml) n_last++;
            if (o.complete && t_done == 0) t_done = k;
        end
        st[sel] = 1'b0;
    endtask

    vec_t vecs [14];
    int   nl, td, extra_last, last_out, kk;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        st     = 3'b000;
        rs     = 3'b111;
        step(2);
        step(2);
        rs[1] = 1'b0;
        rs[2] = 1'b0;

        //              rst st  busy cmp bv mv mf ml  B  I   W  out
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0);
        vecs[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0);
        vecs[2]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 1,  1, 0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 2,  2, 0);
        vecs[5]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 4,  3, 0);
        vecs[6]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 5,  4, 0);
        vecs[7]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 6,  5, 0);
        vecs[8]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 8,  6, 0);
        vecs[9]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 9,  7, 0);
        vecs[10] = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 10, 8, 0);
        vecs[11] = mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 10, 8, 0);
        vecs[12] = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 1,  0, 0);
        vecs[13] = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 2,  1, 0);

        // Config A (RP=CP=2, T=40): entry 0 is rst+start together, entry 1 is E0.
        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            rs[0] = vecs[v].rst;
            st[0] = vecs[v].start;
            step(0);
            check_obs("vecA", v, o, vecs[v].exp);
        end
        st[0] = 1'b0;

        // Finish run A: three more pixels, complete at cycle 42.
        extra_last = 0;
        last_out   = -1;
        td         = 0;
        kk         = 13;
        while (kk < 80 && td == 0) begin
            step(0);
            kk++;
            if (o.ml) begin
                extra_last++;
                last_out = int'(o.out);
            end
            if (o.complete) td = kk;
        end
        check("A mac_last count", kk, 32'(extra_last), 32'd3);
        check("A final out_idx", kk, 32'(last_out), 32'd3);
        check("A complete cycle", kk, 32'(td), 32'd42);

        // Start from DONE with a stray start pulse mid-run: identical second run.
        st[0] = 1'b1;
        watch(0, 1, 1, 4, 4, 3, 1, 44, 20, nl, td);
        check("A2 mac_last count", 44, 32'(nl), 32'd4);
        check("A2 complete cycle", 44, 32'(td), 32'd42);

        // Config B, stride 2: pixel 3 spans I_addr 12..24.
        st[1] = 1'b1;
        watch(1, 1, 1, 5, 5, 3, 2, 43, 0, nl, td);
        check("B mac_last count", 43, 32'(nl), 32'd4);
        check("B complete cycle", 43, 32'(td), 32'd42);

        // Default config: abort with rst during cycle 500.
        st[2] = 1'b1;
        watch(2, 3, 3, 28, 28, 4, 1, 500, 0, nl, td);
        rs[2] = 1'b1;
        step(2);
        check_obs("D reset", 501, o, '0);
        rs[2] = 1'b0;
        for (int k = 502; k < 507; k++) begin
            step(2);
            check_obs("D post-reset idle", k, o, '0);
        end

        // Full default run from scratch.
        st[2] = 1'b1;
        watch(2, 3, 3, 28, 28, 4, 1, 91878, 0, nl, td);
        check("D mac_last count", 91878, 32'(nl), 32'd1875);
        check("D complete cycle", 91878, 32'(td), 32'd91877);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
